// File: rtl/ahb_gpio_sequencer.sv
// ahb_gpio_sequencer: arbitrates two command requesters round-robin and
// issues one single-beat AHB-Lite transfer at a time. Each transfer phase
// (address and data) is bounded by a wait-state timeout that completes the
// command with an error flag instead of hanging the requester.
module ahb_gpio_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [63:0]         req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                HSEL,
  output logic [31:0]         HADDR,
  output logic [1:0]          HTRANS,
  output logic                HWRITE,
  output logic [DATA_W-1:0]   HWDATA,
  output logic                HREADY,
  input  logic                HREADYOUT,
  input  logic [DATA_W-1:0]   HRDATA
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // The phase times out on the low-HREADYOUT cycle that would bring the
  // counter to TIMEOUT, so comparing against TIMEOUT-1 suffices.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  // FSM and captured command
  logic [1:0]        r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_last_grant;
  logic              r_grant;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Registered outputs
  logic [1:0]        r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_hsel;
  logic [31:0]       r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [DATA_W-1:0] r_hwdata;

  // Combinational helpers
  logic [1:0]        w_next_state;
  logic              w_grant_sel;
  logic              w_accept;
  logic              w_in_phase;
  logic              w_timeout;
  logic [1:0]        w_req_ready;
  logic [31:0]       w_sel_addr;
  logic              w_sel_write;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_accept    = (r_state == S_IDLE) && (req_valid != 2'b00) && !HRESET;
  assign w_in_phase  = (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_timeout   = w_in_phase && !HREADYOUT && (r_wait_cnt == WAIT_LAST);
  assign w_sel_addr  = w_grant_sel ? req_addr[63:32] : req_addr[31:0];
  assign w_sel_write = w_grant_sel ? req_write[1] : req_write[0];
  assign w_sel_wdata = w_grant_sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  // Round-robin pick: alternate when both ask, otherwise the lone requester wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      w_grant_sel = ~r_last_grant;
    end else if (req_valid[0]) begin
      w_grant_sel = 1'b0;
    end else begin
      w_grant_sel = 1'b1;
    end
  end

  // One-hot acceptance pulse toward the granted requester, only in IDLE.
  always_comb begin
    w_req_ready = 2'b00;
    if (w_accept) begin
      if (w_grant_sel) begin
        w_req_ready = 2'b10;
      end else begin
        w_req_ready = 2'b01;
      end
    end else begin
      w_req_ready = 2'b00;
    end
  end

  // Next-state logic for the single-outstanding-transfer FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_ADDR;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADDR: begin
        if (HREADYOUT) begin
          w_next_state = S_DATA;
        end else if (w_timeout) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_DATA: begin
        if (HREADYOUT || w_timeout) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_RESP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM state, wait counter, arbitration history and command/result capture.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= 8'd0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= {DATA_W{1'b0}};
      r_rdata      <= {DATA_W{1'b0}};
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;

      if (w_next_state != r_state) begin
        r_wait_cnt <= 8'd0;
      end else if (w_in_phase && !HREADYOUT) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end

      if (w_accept) begin
        r_grant      <= w_grant_sel;
        r_last_grant <= w_grant_sel;
        r_write      <= w_sel_write;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
        r_rdata      <= {DATA_W{1'b0}};
        r_err        <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= {DATA_W{1'b0}};
        r_err   <= 1'b1;
      end else if ((r_state == S_DATA) && HREADYOUT) begin
        r_rdata <= r_write ? {DATA_W{1'b0}} : HRDATA;
      end
    end
  end

  // Bus and response outputs registered from the next state so they line up
  // with the FSM phase and never glitch.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_hsel      <= 1'b0;
      r_haddr     <= 32'd0;
      r_htrans    <= HTRANS_IDLE;
      r_hwrite    <= 1'b0;
      r_hwdata    <= {DATA_W{1'b0}};
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      if (w_next_state == S_ADDR) begin
        r_hsel   <= 1'b1;
        r_htrans <= HTRANS_NONSEQ;
        r_haddr  <= (r_state == S_IDLE) ? w_sel_addr : r_addr;
        r_hwrite <= (r_state == S_IDLE) ? w_sel_write : r_write;
      end else begin
        r_hsel   <= 1'b0;
        r_htrans <= HTRANS_IDLE;
        r_haddr  <= 32'd0;
        r_hwrite <= 1'b0;
      end

      if ((w_next_state == S_DATA) && r_write) begin
        r_hwdata <= r_wdata;
      end else begin
        r_hwdata <= {DATA_W{1'b0}};
      end

      if (r_state == S_RESP) begin
        r_rsp_valid <= r_grant ? 2'b10 : 2'b01;
        r_rsp_err   <= r_err;
        r_rsp_rdata <= r_rdata;
      end else begin
        r_rsp_valid <= 2'b00;
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= {DATA_W{1'b0}};
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign HSEL      = r_hsel;
  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HWDATA    = r_hwdata;
  assign HREADY    = HREADYOUT;

endmodule

// File: doc/ahb_gpio_sequencer.md
AHB_GPIO_SEQUENCER -- requirements
Module: ahb_gpio_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of AHB write data, read data and requester data.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the wait-state limit per transfer phase in cycles (range 2..255).
REQ-003 Port HCLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req_valid, input, 2 bits: per-requester command valid.
REQ-006 Port req_ready, output, 2 bits: per-requester command accepted (one-hot pulse).
REQ-007 Port req_write, input, 2 bits: per-requester command direction (1 = write).
REQ-008 Port req_addr, input, 64 bits: {req1_addr, req0_addr}.
REQ-009 Port req_wdata, input, 2*DATA_W bits: {req1_wdata, req0_wdata}.
REQ-010 Port rsp_valid, output, 2 bits: per-requester completion pulse.
REQ-011 Port rsp_err, output, 1 bit: timeout flag, qualified by rsp_valid.
REQ-012 Port rsp_rdata, output, DATA_W bits: read data, qualified by rsp_valid.
REQ-013 Port HSEL, output, 1 bit: slave select.
REQ-014 Port HADDR, output, 32 bits: transfer address.
REQ-015 Port HTRANS, output, 2 bits: transfer type, IDLE = 2'b00 or NONSEQ = 2'b10.
REQ-016 Port HWRITE, output, 1 bit: transfer direction.
REQ-017 Port HWDATA, output, DATA_W bits: write data.
REQ-018 Port HREADY, output, 1 bit: bus ready to the slave, equal to HREADYOUT.
REQ-019 Port HREADYOUT, input, 1 bit: slave ready.
REQ-020 Port HRDATA, input, DATA_W bits: slave read data.

Function
REQ-021 The FSM SHALL have states IDLE, ADDR, DATA and RESP; only one AHB transfer SHALL be outstanding at a time.
REQ-022 IDLE: when any req_valid bit is 1, the block SHALL grant one requester, pulse its req_ready for that cycle, capture write/addr/wdata, and go to ADDR.
REQ-023 Arbitration SHALL be round-robin: if both requesters are valid, the grant SHALL go to the requester not granted last; a lone valid requester SHALL win regardless of history.
REQ-024 ADDR: HSEL SHALL be 1, HTRANS SHALL be NONSEQ, and HADDR/HWRITE SHALL carry the captured command.
REQ-025 ADDR exit: the block SHALL go to DATA at the first edge with HREADYOUT = 1.
REQ-026 DATA: HSEL SHALL be 0 and HTRANS SHALL be IDLE; HWDATA SHALL hold the captured wdata for writes and be 0 for reads.
REQ-027 DATA exit: at the first edge with HREADYOUT = 1, the block SHALL capture HRDATA (reads only) and go to RESP.
REQ-028 RESP: the block SHALL assert rsp_valid[grant] for exactly one cycle, with rsp_rdata = captured data (0 for writes) and rsp_err = 0, then return to IDLE.
REQ-029 Minimum latency SHALL be 4 cycles, from the req_ready pulse to the rsp_valid pulse, with zero wait states.
REQ-030 A wait counter SHALL clear on entry to ADDR and on entry to DATA, and SHALL increment on each cycle in which HREADYOUT = 0.
REQ-031 When the wait counter reaches TIMEOUT, the block SHALL go to RESP with rsp_err = 1 and rsp_rdata = 0, and HTRANS SHALL be IDLE from that cycle on.
REQ-032 req_ready SHALL be 0 in ADDR, DATA and RESP; a new command SHALL be accepted no earlier than the cycle after RESP.
REQ-033 Requester commands SHALL be sampled only at acceptance; later changes on req_* SHALL NOT affect the transfer in flight.
REQ-034 In IDLE and RESP, HSEL SHALL be 0, HTRANS SHALL be IDLE and HWRITE SHALL be 0.

Reset
REQ-035 While HRESET = 1 at a rising edge, the block SHALL go to IDLE, clear the wait counter, and set the last-grant pointer to requester 1, so requester 0 wins first.
REQ-036 At reset, req_ready, rsp_valid, rsp_err, rsp_rdata, HSEL, HADDR, HTRANS, HWRITE and HWDATA SHALL all be 0.
REQ-037 Reset mid-transfer SHALL abort the transfer with no rsp_valid; the AHB outputs SHALL be IDLE on the next cycle.

Verification
REQ-038 Write test: req0 write addr 0x04, wdata 0xFFFF, zero wait states -> HTRANS = NONSEQ for 1 cycle, HWDATA = 0xFFFF the next cycle, then rsp_valid = 2'b01 with rsp_err = 0.
REQ-039 Read test: req1 read addr 0x00, HRDATA = 0x1A5A -> rsp_valid = 2'b10 and rsp_rdata = 0x1A5A, 4 cycles after req_ready.
REQ-040 Arbitration test: both requesters held valid for 4 commands after reset -> grant order 0, 1, 0, 1.
REQ-041 Wait-state test: HREADYOUT low for 3 cycles in DATA -> rsp_valid 3 cycles later than the zero-wait case, with rsp_err = 0.
REQ-042 Timeout test: HREADYOUT held 0 with TIMEOUT = 16 -> rsp_err = 1 and rsp_rdata = 0 after 16 wait cycles, and the next command proceeds normally.
REQ-043 Reset test: HRESET asserted during DATA -> no rsp_valid, all outputs 0 next cycle, and the first grant after release goes to req0.
